// File: rtl/apb_cfg_master_pkg.sv
// rtl/apb_cfg_master_pkg.sv - shared types and constants for the APB command initiator
package apb_cfg_master_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_t;

    localparam int          DATA_W    = 32;
    localparam logic [31:0] ERR_RDATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/apb_cfg_master.sv
// rtl/apb_cfg_master.sv - single-outstanding command to APB3 initiator with wait-state timeout
module apb_cfg_master
    import apb_cfg_master_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [31:0]       cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] apb_master_paddr,
    output logic              apb_master_psel,
    output logic              apb_master_penable,
    output logic              apb_master_pwrite,
    output logic [31:0]       apb_master_pwdata,
    input  logic [31:0]       apb_master_prdata,
    input  logic              apb_master_pready,
    input  logic              apb_master_pslverr
);

    localparam int               CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_TMO = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_SAT = {CNT_W{1'b1}};

    state_t              state_q, state_d;
    logic                rst_done_q;
    logic                cmd_write_q;
    logic [ADDR_W-1:0]   cmd_addr_q;
    logic [DATA_W-1:0]   cmd_wdata_q;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                psel_q, penable_q;
    logic [CNT_W-1:0]    wait_cnt_q;
    logic                load_cmd;
    logic                timeout_hit;

    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt_q == CNT_TMO);

    always_comb begin
        state_d     = state_q;
        load_cmd    = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: begin
                if (cmd_valid && rst_done_q) begin
                    load_cmd = 1'b1;
                    if (cmd_addr[1:0] != 2'b00) begin
                        state_d     = RESP;
                        rsp_rdata_d = ERR_RDATA;
                        rsp_err_d   = 1'b1;
                    end else begin
                        state_d = SETUP;
                    end
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // A completing slave wins over a timeout landing on the same cycle.
                if (apb_master_pready) begin
                    state_d   = RESP;
                    rsp_err_d = apb_master_pslverr;
                    if (cmd_write_q)
                        rsp_rdata_d = '0;
                    else if (apb_master_pslverr)
                        rsp_rdata_d = ERR_RDATA;
                    else
                        rsp_rdata_d = apb_master_prdata;
                end else if (timeout_hit) begin
                    state_d     = RESP;
                    rsp_rdata_d = ERR_RDATA;
                    rsp_err_d   = 1'b1;
                end
            end
            RESP: begin
                if (rsp_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            rst_done_q <= 1'b0;
            psel_q     <= 1'b0;
            penable_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            psel_q     <= (state_d == SETUP) || (state_d == ACCESS);
            penable_q  <= (state_d == ACCESS);
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cmd_write_q <= 1'b0;
            cmd_addr_q  <= '0;
            cmd_wdata_q <= '0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            if (load_cmd) begin
                cmd_write_q <= cmd_write;
                cmd_addr_q  <= cmd_addr;
                cmd_wdata_q <= cmd_wdata;
            end
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // ACCESS is only ever entered from SETUP, so SETUP is where the count restarts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wait_cnt_q <= '0;
        end else if (state_q == SETUP) begin
            wait_cnt_q <= '0;
        end else if (state_q == ACCESS && !apb_master_pready && wait_cnt_q != CNT_SAT) begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
        end
    end

    assign cmd_ready          = rst_done_q && (state_q == IDLE);
    assign rsp_valid          = (state_q == RESP);
    assign rsp_rdata          = rsp_rdata_q;
    assign rsp_err            = rsp_err_q;
    assign apb_master_paddr   = cmd_addr_q;
    assign apb_master_psel    = psel_q;
    assign apb_master_penable = penable_q;
    assign apb_master_pwrite  = cmd_write_q;
    assign apb_master_pwdata  = cmd_wdata_q;

endmodule

// File: tb/tb_apb_cfg_master.sv
// tb/tb_apb_cfg_master.sv - self-checking bench for apb_cfg_master
module tb_apb_cfg_master;

    localparam int ADDR_W = 4;
    localparam int TMO    = 4;

    logic              clk = 1'b0;
    logic              rstn;
    logic              cmd_valid, cmd_ready, cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [31:0]       cmd_wdata;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [31:0]       rsp_rdata;
    logic [ADDR_W-1:0] paddr;
    logic              psel, penable, pwrite, pready, pslverr;
    logic [31:0]       pwdata, prdata;

    always #5 clk = ~clk;

    apb_cfg_master #(.ADDR_W(ADDR_W), .TIMEOUT(TMO)) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .apb_master_paddr(paddr), .apb_master_psel(psel), .apb_master_penable(penable),
        .apb_master_pwrite(pwrite), .apb_master_pwdata(pwdata), .apb_master_prdata(prdata),
        .apb_master_pready(pready), .apb_master_pslverr(pslverr)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Slave: wait_cfg low-ready cycles per transfer, then completes with err_cfg.
    logic [31:0] smem [4] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};
    int   wait_cfg = 0;
    int   wait_left = 0;
    logic err_cfg = 1'b0;

    always @(negedge clk) begin
        if (psel && !penable) begin
            wait_left = wait_cfg;
            pready    = 1'b0;
            pslverr   = 1'b0;
        end else if (psel && penable) begin
            if (wait_left > 0) begin
                pready  = 1'b0;
                pslverr = 1'b0;
                wait_left--;
            end else begin
                pready  = 1'b1;
                prdata  = smem[paddr[3:2]];
                pslverr = err_cfg;
                if (pwrite && !err_cfg)
                    smem[paddr[3:2]] = pwdata;
            end
        end else begin
            pready  = 1'b0;
            pslverr = 1'b0;
        end
    end

    typedef struct {
        logic        w;
        logic [3:0]  a;
        logic [31:0] wd;
        int          waits;
        logic        serr;
        logic [31:0] exp_rd;
        logic        exp_e;
        int          exp_lat;
    } vec_t;

    // Reference: register file of four words behind a slave with a fixed stall count.
    logic [31:0] mm [4] = '{32'hC0DE0000, 32'hC0DE0001, 32'hC0DE0002, 32'hC0DE0003};

    function automatic void model(input vec_t v, output logic [31:0] rd, output logic e,
                                  output int lat, output int pc);
        if (v.a[1:0] != 2'b00) begin
            rd = 32'hFFFF_FFFF; e = 1'b1; lat = 1; pc = 0;
        end else if (v.waits > TMO) begin
            rd = 32'hFFFF_FFFF; e = 1'b1; lat = TMO + 3; pc = TMO + 2;
        end else begin
            lat = 3 + v.waits;
            pc  = 2 + v.waits;
            e   = v.serr;
            if (v.w) begin
                rd = 32'h0;
                if (!v.serr) mm[v.a[3:2]] = v.wd;
            end else begin
                rd = v.serr ? 32'hFFFF_FFFF : mm[v.a[3:2]];
            end
        end
    endfunction

    task automatic run_txn(input vec_t v, input int hold, output logic [31:0] rd,
                           output logic e, output int lat, output int pc, output int hs);
        logic bad_bus, bad_rdy, bad_hold;
        bad_bus = 0; bad_rdy = 0; bad_hold = 0;
        pc = 0; lat = -1; rd = '0; e = 1'b0;
        wait_cfg = v.waits;
        err_cfg  = v.serr;
        chk("cmd_ready in idle", cmd_ready, 1'b1);
        cmd_valid = 1'b1; cmd_write = v.w; cmd_addr = v.a; cmd_wdata = v.wd;
        @(posedge clk);
        hs = cyc;
        for (int k = 1; k <= 60; k++) begin
            @(negedge clk);
            if (psel) begin
                pc++;
                if (paddr !== v.a || pwrite !== v.w || (v.w && pwdata !== v.wd)) bad_bus = 1;
            end
            if (cmd_ready) bad_rdy = 1;
            if (rsp_valid) begin
                lat = k; rd = rsp_rdata; e = rsp_err;
                break;
            end
            cmd_write = 1'($urandom); cmd_addr = 4'($urandom); cmd_wdata = $urandom;
        end
        cmd_valid = 1'b0;
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || rsp_err !== e || cmd_ready) bad_hold = 1;
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("apb bus stable", {31'b0, bad_bus}, 0);
        chk("cmd_ready low while busy", {31'b0, bad_rdy}, 0);
        if (hold > 0) chk("response held", {31'b0, bad_hold}, 0);
        chk("cmd_ready after rsp", cmd_ready, 1'b1);
    endtask

    task automatic do_check(input vec_t v, input int hold, input int use_table);
        logic [31:0] rd, mrd;
        logic        e, me;
        int          lat, pc, hs, mlat, mpc;
        run_txn(v, hold, rd, e, lat, pc, hs);
        model(v, mrd, me, mlat, mpc);
        if (use_table != 0) begin
            mrd = v.exp_rd; me = v.exp_e; mlat = v.exp_lat;
        end
        chk($sformatf("rdata a=%h w=%0d", v.a, v.w), rd, mrd);
        chk($sformatf("err a=%h w=%0d", v.a, v.w), {31'b0, e}, {31'b0, me});
        chk($sformatf("latency a=%h waits=%0d", v.a, v.waits), lat, mlat);
        chk($sformatf("psel cycles a=%h waits=%0d", v.a, v.waits), pc, mpc);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t tbl [8];
        vec_t v;
        logic [31:0] rd;
        logic e, bad;
        int lat, pc, hs1, hs2;

        tbl[0] = '{1'b1, 4'h8, 32'h775F3F1C, 0, 1'b0, 32'h00000000, 1'b0, 3};
        tbl[1] = '{1'b0, 4'h8, 32'h0,        0, 1'b0, 32'h775F3F1C, 1'b0, 3};
        tbl[2] = '{1'b0, 4'hC, 32'h0,        3, 1'b0, 32'hC0DE0003, 1'b0, 6};
        tbl[3] = '{1'b1, 4'h5, 32'hAAAA5555, 0, 1'b0, 32'hFFFFFFFF, 1'b1, 1};
        tbl[4] = '{1'b0, 4'h4, 32'h0,        1, 1'b1, 32'hFFFFFFFF, 1'b1, 4};
        tbl[5] = '{1'b1, 4'h4, 32'h12345678, 9, 1'b0, 32'hFFFFFFFF, 1'b1, 7};
        tbl[6] = '{1'b0, 4'h4, 32'h0,        0, 1'b0, 32'hC0DE0001, 1'b0, 3};
        tbl[7] = '{1'b0, 4'h0, 32'h0,        2, 1'b0, 32'hC0DE0000, 1'b0, 5};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        rsp_ready = 1'b0; pready = 1'b0; pslverr = 1'b0; prdata = '0;
        repeat (3) @(negedge clk);
        chk("reset cmd_ready", cmd_ready, 1'b0);
        chk("reset psel/penable", {30'b0, psel, penable}, 0);
        chk("reset rsp_valid/err", {30'b0, rsp_valid, rsp_err}, 0);
        chk("reset rsp_rdata", rsp_rdata, 0);
        chk("reset paddr/pwrite", {27'b0, paddr, pwrite}, 0);
        chk("reset pwdata", pwdata, 0);
        rstn = 1'b1;
        @(negedge clk);
        chk("cmd_ready after release", cmd_ready, 1'b1);

        for (int i = 0; i < 8; i++) begin
            do_check(tbl[i], 0, 1);
            if (i == 0) chk("slave reg after write", smem[2], 32'h775F3F1C);
        end

        v = '{1'b0, 4'h8, 32'h0, 1, 1'b0, 32'h0, 1'b0, 0};
        do_check(v, 10, 0);

        v = '{1'b1, 4'hC, 32'h01020304, 0, 1'b0, 32'h0, 1'b0, 0};
        run_txn(v, 0, rd, e, lat, pc, hs1);
        model(v, rd, e, lat, pc);
        v.wd = 32'h05060708;
        run_txn(v, 0, rd, e, lat, pc, hs2);
        model(v, rd, e, lat, pc);
        chk("back-to-back spacing", hs2 - hs1, 4);

        wait_cfg = 20; err_cfg = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 4'h8; cmd_wdata = 32'h0BADF00D;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("in access before reset", {30'b0, psel, penable}, 3);
        #2 rstn = 1'b0;
        #1;
        chk("async drop psel/penable", {30'b0, psel, penable}, 0);
        chk("reset rsp_valid/cmd_ready", {30'b0, rsp_valid, cmd_ready}, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1; wait_cfg = 0;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (rsp_valid || psel) bad = 1'b1;
        end
        chk("no response after reset", {31'b0, bad}, 0);
        do_check('{1'b1, 4'h0, 32'h600DF00D, 0, 1'b0, 32'h0, 1'b0, 0}, 0, 0);
        do_check('{1'b0, 4'h0, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0}, 0, 0);
        do_check('{1'b0, 4'h8, 32'h0, 0, 1'b0, 32'h0, 1'b0, 0}, 0, 0);

        for (int i = 0; i < 40; i++) begin
            v.w  = 1'($urandom);
            v.a  = 4'($urandom) & 4'hC;
            if ($urandom_range(0, 4) == 0) v.a[1:0] = 2'($urandom_range(1, 3));
            v.wd = $urandom;
            v.waits = $urandom_range(0, 7);
            v.serr  = !v.w && ($urandom_range(0, 5) == 0);
            do_check(v, $urandom_range(0, 2), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
